// File: rtl/pop_counters_param.sv
// Bank of NUM_CH independent event counters with a registered one-cycle read port.
// Reads can clear the selected counter. Each channel has a sticky overflow flag.
module pop_counters_param #(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 5,
  parameter int IDX_W    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pop,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic              rd_clr,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic              err,
  output logic [NUM_CH-1:0] ovf
);

  // Read handshake: req is sampled at every rising edge and the port never stalls.
  // valid is high for exactly the cycle after a req edge. err is meaningful only
  // while valid is high. data_out holds its last value while valid is low.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  data_q, data_d;

  logic              in_range;
  logic [CNT_W-1:0]  rd_sel;
  logic [NUM_CH-1:0] clr_sel;

  // Read mux and clear decode. Out-of-range indices select no channel.
  always_comb begin
    in_range = (32'(idx) < NUM_CH);
    rd_sel   = '0;
    clr_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_sel     = cnt_q[i];
        clr_sel[i] = req & rd_clr;
      end
    end
  end

  // Per-channel next state. A clearing read restarts the count at this edge's pop.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr_sel[i]) begin
        cnt_d[i] = pop[i] ? CNT_W'(1) : '0;
        ovf_d[i] = pop[i] & (cnt_q[i] == CNT_MAX);
      end else if (pop[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i] = SATURATE ? CNT_MAX : '0;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    valid_d = req;
    err_d   = req & ~in_range;
    data_d  = data_q;
    if (req) begin
      data_d = in_range ? rd_sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign err      = err_q;
  assign data_out = data_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pop_counters_param.sv
// Directed plus random bench for pop_counters_param. A wrapping and a saturating
// instance share all inputs and are checked every cycle against an integer model.
module tb_pop_counters_param;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = 3;
  localparam int MAXV   = 31;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] pop;
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic              rd_clr;

  logic              valid_w, err_w, valid_s, err_s;
  logic [CNT_W-1:0]  data_w, data_s;
  logic [NUM_CH-1:0] ovf_w, ovf_s;

  pop_counters_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .pop(pop), .req(req), .idx(idx), .rd_clr(rd_clr),
    .valid(valid_w), .data_out(data_w), .err(err_w), .ovf(ovf_w)
  );

  pop_counters_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .pop(pop), .req(req), .idx(idx), .rd_clr(rd_clr),
    .valid(valid_s), .data_out(data_s), .err(err_s), .ovf(ovf_s)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain integer counts per channel
  int m_cnt_w [NUM_CH];
  int m_cnt_s [NUM_CH];
  bit m_ovf_w [NUM_CH];
  bit m_ovf_s [NUM_CH];
  bit m_valid, m_err;
  int m_data_w, m_data_s;

  logic [31:0] exp_q [$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ovf_vec(input bit s);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = s ? m_ovf_s[i] : m_ovf_w[i];
    return v;
  endfunction

  task automatic model_edge(input logic [NUM_CH-1:0] p, input logic r, input int ix,
                            input logic rc, input logic rs);
    if (rs) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt_w[i] = 0; m_cnt_s[i] = 0; m_ovf_w[i] = 0; m_ovf_s[i] = 0;
      end
      m_valid = 0; m_err = 0; m_data_w = 0; m_data_s = 0;
    end else begin
      m_valid = r;
      m_err   = r && (ix >= NUM_CH);
      if (r) begin
        m_data_w = (ix < NUM_CH) ? m_cnt_w[ix] : 0;
        m_data_s = (ix < NUM_CH) ? m_cnt_s[ix] : 0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (r && rc && ix == i) begin
          m_ovf_w[i] = p[i] && (m_cnt_w[i] == MAXV);
          m_ovf_s[i] = p[i] && (m_cnt_s[i] == MAXV);
          m_cnt_w[i] = p[i] ? 1 : 0;
          m_cnt_s[i] = p[i] ? 1 : 0;
        end else if (p[i]) begin
          if (m_cnt_w[i] == MAXV) m_ovf_w[i] = 1;
          if (m_cnt_s[i] == MAXV) m_ovf_s[i] = 1;
          m_cnt_w[i] = (m_cnt_w[i] + 1) % (MAXV + 1);
          m_cnt_s[i] = (m_cnt_s[i] < MAXV) ? m_cnt_s[i] + 1 : MAXV;
        end
      end
    end
    exp_q.push_back(32'(m_data_w));
    exp_q.push_back(32'(m_data_s));
  endtask

  // driver: apply one cycle of inputs, advance the model, check all outputs
  task automatic cyc(input logic [NUM_CH-1:0] p, input logic r, input int ix,
                     input logic rc, input logic rs);
    logic [31:0] ew, es;
    pop = p; req = r; idx = IDX_W'(ix); rd_clr = rc; reset = rs;
    @(posedge clk);
    model_edge(p, r, ix, rc, rs);
    #1;
    ew = exp_q.pop_front();
    es = exp_q.pop_front();
    check("w_valid", 32'(valid_w), 32'(m_valid));
    check("w_err",   32'(err_w),   32'(m_err));
    check("w_data",  32'(data_w),  ew);
    check("w_ovf",   32'(ovf_w),   ovf_vec(1'b0));
    check("s_valid", 32'(valid_s), 32'(m_valid));
    check("s_err",   32'(err_s),   32'(m_err));
    check("s_data",  32'(data_s),  es);
    check("s_ovf",   32'(ovf_s),   ovf_vec(1'b1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc('0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    pop = '0; req = 1'b0; idx = '0; rd_clr = 1'b0; reset = 1'b1;
    @(negedge clk);

    // reset state
    cyc('0, 1'b0, 0, 1'b0, 1'b1);
    cyc('0, 1'b0, 0, 1'b0, 1'b1);
    idle(1);

    // all channels pop together for 3 cycles, then read each
    for (int k = 0; k < 3; k++) cyc(5'b11111, 1'b0, 0, 1'b0, 1'b0);
    cyc('0, 1'b1, 2, 1'b0, 1'b0);
    check("req033_data", 32'(data_w), 32'd3);
    for (int ch = 0; ch < NUM_CH; ch++) cyc('0, 1'b1, ch, 1'b0, 1'b0);
    idle(2);

    // out-of-range reads, with rd_clr, must not disturb anything
    cyc('0, 1'b1, 6, 1'b1, 1'b0);
    check("req036_err", 32'(err_w), 32'd1);
    cyc('0, 1'b1, 5, 1'b1, 1'b0);
    cyc('0, 1'b1, 7, 1'b0, 1'b0);
    for (int ch = 0; ch < NUM_CH; ch++) cyc('0, 1'b1, ch, 1'b0, 1'b0);

    // rd_clr without req has no effect
    cyc('0, 1'b0, 0, 1'b1, 1'b0);
    cyc('0, 1'b1, 0, 1'b0, 1'b0);

    // 33 pops on ch0: wrap vs saturate, ovf in both
    cyc('0, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 33; k++) cyc(5'b00001, 1'b0, 0, 1'b0, 1'b0);
    cyc('0, 1'b1, 0, 1'b0, 1'b0);
    check("req034_wrap", 32'(data_w), 32'd1);
    check("req034_sat",  32'(data_s), 32'd31);
    check("req034_ovf",  32'(ovf_w[0] & ovf_s[0]), 32'd1);
    cyc('0, 1'b1, 0, 1'b1, 1'b0);
    cyc('0, 1'b1, 0, 1'b0, 1'b0);

    // clearing read with a coincident pop
    cyc('0, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) cyc(5'b00010, 1'b0, 0, 1'b0, 1'b0);
    cyc(5'b00010, 1'b1, 1, 1'b1, 1'b0);
    check("req035_first", 32'(data_w), 32'd7);
    cyc('0, 1'b1, 1, 1'b0, 1'b0);
    check("req035_second", 32'(data_w), 32'd1);
    idle(1);

    // back-to-back reads while popping
    cyc('0, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cyc(5'b01000, 1'b1, 3, 1'b0, 1'b0);
    idle(1);

    // reset during a pending response, and req coincident with reset
    for (int k = 0; k < 4; k++) cyc(5'b10101, 1'b0, 0, 1'b0, 1'b0);
    cyc('0, 1'b1, 0, 1'b0, 1'b0);
    cyc(5'b11111, 1'b1, 2, 1'b1, 1'b1);
    check("req038_valid", 32'(valid_w), 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++) cyc('0, 1'b1, ch, 1'b0, 1'b0);

    // randomized traffic, pops biased high to reach the max value
    for (int k = 0; k < 600; k++) begin
      cyc(NUM_CH'($urandom_range(0, 31) | $urandom_range(0, 31)),
          1'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 149) == 0));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pop_counters_param.md
POP_COUNTERS_PARAM -- requirements
Module: pop_counters_param

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of independent pop counters (1..8).
REQ-002 SHALL have parameter CNT_W, default 5, counter and data_out width in bits (2..16).
REQ-003 SHALL have parameter IDX_W, default 3, idx width; 2^IDX_W >= NUM_CH.
REQ-004 SHALL have parameter SATURATE, default 0; 0 = counters wrap, 1 = counters saturate at 2^CNT_W-1.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 pop  input  NUM_CH  per-channel pop event strobe; bit i counts for channel i.
REQ-009 req  input  1  read request, sampled each rising edge.
REQ-010 idx  input  IDX_W  channel selected by req.
REQ-011 rd_clr  input  1  with req: clear selected counter after read.
REQ-012 valid  output  1  one-cycle read response strobe.
REQ-013 data_out  output  CNT_W  read response count.
REQ-014 err  output  1  with valid: idx out of range.
REQ-015 ovf  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-016 SHALL increment counter i by 1 on every edge with pop[i]=1; all channels popping in the same cycle SHALL each be counted (no priority, no lost events).
REQ-017 At max value with pop[i]=1: SATURATE=0 SHALL wrap to 0; SATURATE=1 SHALL hold at max.
REQ-018 SHALL set ovf[i] on any edge where counter i is at max and pop[i]=1, in either mode; ovf[i] stays set until reset or rd_clr read of channel i.
REQ-019 Read latency SHALL be exactly 1 cycle: req=1 at edge N -> valid=1 for the cycle following edge N, driven from registers.
REQ-020 data_out SHALL equal the selected counter value before edge N's update (pops at edge N are not included).
REQ-021 A read SHALL return the value even when it is 0 (no suppression of zero counts).
REQ-022 req with idx >= NUM_CH SHALL give valid=1, err=1, data_out=0, no state change.
REQ-023 err SHALL be 0 whenever valid=0 or idx is in range.
REQ-024 When req=0, valid SHALL be 0 next cycle and data_out SHALL hold its last value.
REQ-025 Back-to-back req every cycle SHALL give valid every cycle; no stall, no busy state.
REQ-026 req+rd_clr on channel i at edge N: counter i SHALL become 1 if pop[i]=1 at edge N, else 0; ovf[i] SHALL clear unless re-set at the same edge per REQ-018.
REQ-027 rd_clr SHALL have no effect when req=0 or idx is out of range.
REQ-028 Counters of non-selected channels SHALL be unaffected by req/rd_clr.

Reset
REQ-029 reset=1 at a rising edge SHALL set all counters 0, ovf 0, valid 0, err 0, data_out 0.
REQ-030 reset SHALL dominate pop, req and rd_clr at the same edge; a req issued at that edge SHALL produce no response.
REQ-031 Reset during a pending response (req at edge N, reset at edge N+1) SHALL force valid=0 after edge N+1.
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-033 Defaults; pop=5'b11111 for 3 cycles, then req idx=2 -> valid=1, data_out=3, err=0; all channels read 3.
REQ-034 SATURATE=0, CNT_W=5: 33 pops ch0, read -> data_out=1, ovf[0]=1; SATURATE=1 same stimulus -> data_out=31, ovf[0]=1.
REQ-035 Ch1 at 7; req idx=1, rd_clr=1, pop[1]=1 same edge -> data_out=7; next read -> 1; ovf[1]=0.
REQ-036 req idx=6 with NUM_CH=5 -> valid=1, err=1, data_out=0; counters unchanged.
REQ-037 req idx=3 every cycle for 4 cycles with pop[3]=1 continuously from 0 -> data_out 0,1,2,3 on consecutive cycles.
REQ-038 Counters nonzero; req at edge N, reset at edge N+1 -> valid=0, data_out=0, subsequent reads return 0.
